// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
//
// Word-addressed data memory for a multicycle datapath. It has a valid/ready
// request channel and a valid/ready response channel. Each request passes
// through a fixed number of wait states and is then answered with exactly one
// response. Only one transaction is in flight at a time.
//
// Parameters
//   DEPTH        number of 32-bit words (power of two, 4..1024)
//   WAIT_CYCLES  wait states between acceptance and response (0..15)
//
// Ports
//   clk          single clock; all state changes on its rising edge
//   reset        synchronous, active-high; clears the FSM, the response
//                registers and every memory word
//   req_valid    datapath presents a load/store
//   req_ready    responder is idle and can accept (low while reset is high)
//   req_we       1 = store, 0 = load
//   req_addr     byte address; word index = req_addr[log2(DEPTH)+1:2]
//   req_wdata    store data
//   resp_valid   response available; held until resp_ready
//   resp_ready   datapath consumes the response
//   resp_rdata   load data; 0 for stores
//   resp_err     address error flag (only when DMEM_ADDR_ERR_EN is defined)
//
// Build option
//   DMEM_ADDR_ERR_EN  When this macro is defined, a misaligned address or an
//                     address >= 4*DEPTH is still answered with the normal
//                     latency. It sets resp_err, returns 0 and writes nothing.
//                     When the macro is undefined, such addresses alias
//                     modulo DEPTH.
//
// Timing
//   The request handshake is seen in cycle c (the edge that ends c accepts it).
//   resp_valid first rises in cycle c+1+WAIT_CYCLES.
//   The memory is read or written on the edge that enters RESP. The load data
//   is therefore registered at the same moment resp_valid rises.
// -----------------------------------------------------------------------------
module data_mem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata
`ifdef DMEM_ADDR_ERR_EN
    ,
    output logic        resp_err
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = 4;
    // The counter is loaded with WAIT_CYCLES-1, so the last wait cycle is
    // the one where the counter reads zero.
    localparam logic [CW-1:0] CNT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;

    // Request fields captured at acceptance.
    logic          we_reg;
    logic [AW-1:0] idx_reg;
    logic [31:0]   wdata_reg;

    logic [31:0]   rdata_reg;

    logic          accept;
    logic          enter_resp;
    logic [AW-1:0] req_idx;

    // Fields used for the memory access on the RESP-entry edge.
    logic          acc_we;
    logic [AW-1:0] acc_idx;
    logic [31:0]   acc_wdata;
    logic          acc_err;
    logic          mem_we;

    logic [DEPTH-1:0]       word_wen;
    logic [DEPTH-1:0][31:0] mem_words;

    // In the default build, the byte-offset bits and the bits above the word
    // index take no part in addressing.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:AW+2], req_addr[1:0]};

    assign req_idx   = req_addr[AW+1:2];
    assign req_ready = (state_reg == ST_IDLE) && !reset;
    assign accept    = req_valid && req_ready;

    // With zero wait states, RESP is entered on the acceptance edge itself.
    // The latched copies do not exist yet at that edge, so the live request
    // is used instead. Otherwise the access uses the latched copies.
    assign acc_we    = (state_reg == ST_IDLE) ? req_we    : we_reg;
    assign acc_idx   = (state_reg == ST_IDLE) ? req_idx   : idx_reg;
    assign acc_wdata = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;

`ifdef DMEM_ADDR_ERR_EN
    logic req_err;
    logic err_reg;
    logic resp_err_reg;

    assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(4 * DEPTH));
    assign acc_err  = (state_reg == ST_IDLE) ? req_err : err_reg;
    assign resp_err = resp_err_reg;
`else
    assign acc_err  = 1'b0;
`endif

    assign mem_we = enter_resp && acc_we && !acc_err;

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next state and access strobe
    // -------------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        enter_resp = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_next = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = ST_WAIT;
                        cnt_next   = CNT_LOAD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_reg == '0) begin
                    state_next = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            ST_RESP: begin
                // Retirement returns to IDLE only. A new request can be
                // accepted in the following cycle at the earliest.
                if (resp_ready) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Request capture. This updates only on acceptance, so requests offered
    // while busy cannot disturb the transaction in flight.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            we_reg    <= 1'b0;
            idx_reg   <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            we_reg    <= req_we;
            idx_reg   <= req_idx;
            wdata_reg <= req_wdata;
        end
    end

`ifdef DMEM_ADDR_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            err_reg <= 1'b0;
        end else if (accept) begin
            err_reg <= req_err;
        end
    end
`endif

    // -------------------------------------------------------------------------
    // Storage. Every word must clear in a single reset cycle, so each word is
    // its own register with a per-word write enable.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            logic [31:0] word_reg;

            assign word_wen[gi] = mem_we && (acc_idx == AW'(gi));

            always_ff @(posedge clk) begin
                if (reset) begin
                    word_reg <= '0;
                end else if (word_wen[gi]) begin
                    word_reg <= acc_wdata;
                end
            end

            assign mem_words[gi] = word_reg;
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Response data. This is captured on the RESP-entry edge and then held
    // unchanged while the response waits for resp_ready. Stores and
    // erroneous accesses return 0.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_reg <= '0;
        end else if (enter_resp) begin
            rdata_reg <= (acc_we || acc_err) ? 32'd0 : mem_words[acc_idx];
        end
    end

`ifdef DMEM_ADDR_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_err_reg <= 1'b0;
        end else if (enter_resp) begin
            resp_err_reg <= acc_err;
        end
    end
`endif

    assign resp_valid = (state_reg == ST_RESP);
    assign resp_rdata = rdata_reg;

endmodule
